// File: rtl/pi_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : pi_mem_arb
// Purpose  : Shares one byte-wide async SRAM port between the MCU serial bus
//            (PiBus) and a host/console requester. Each grant runs a single
//            fixed-timing memory cycle: SETUP, STROBE (MEM_CYC clk), RECOV.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   pi_addr_i         PiBus address, [31:24] selects memory (== PI_BASE)
//   pi_dato_i         PiBus write data
//   pi_we_sync_i      1-clk PiBus write request pulse
//   pi_oe_sync_i      1-clk PiBus read request pulse
//   pi_dati_o         PiBus read data (FF on miss / after reset)
//   pi_ovf_o          sticky: a PiBus request was dropped
//   host_req_i        host request level, held until host_ack_o
//   host_we_i         host direction, 1 = write
//   host_addr_i       host byte address
//   host_wdata_i      host write data
//   host_ack_o        1-clk pulse when a host access completes
//   host_rdata_o      host read data, valid from host_ack_o
//   mem_addr_o/do_o   SRAM address / write data
//   mem_di_i          SRAM read data
//   mem_ce_o/oe_o/we_o SRAM strobes, active high
// ============================================================================
module pi_mem_arb #(
  parameter int          AW      = 21,
  parameter int          MEM_CYC = 3,
  parameter logic [7:0]  PI_BASE = 8'h00
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   pi_addr_i,
  input  logic [7:0]    pi_dato_i,
  input  logic          pi_we_sync_i,
  input  logic          pi_oe_sync_i,
  output logic [7:0]    pi_dati_o,
  output logic          pi_ovf_o,
  input  logic          host_req_i,
  input  logic          host_we_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [7:0]    host_wdata_i,
  output logic          host_ack_o,
  output logic [7:0]    host_rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_do_o,
  input  logic [7:0]    mem_di_i,
  output logic          mem_ce_o,
  output logic          mem_oe_o,
  output logic          mem_we_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_RECOV  = 2'd3
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          cur_pi_q;
  logic          cur_rw_q;
  logic          last_host_q;

  logic          pi_pend_q;
  logic          pi_hit_q;
  logic          pi_rw_q;
  logic [AW-1:0] pi_addr_q;
  logic [7:0]    pi_dat_q;
  logic          pi_ovf_q;
  logic [7:0]    pi_dati_q;

  logic          host_ack_q;
  logic [7:0]    host_rdata_q;
  logic [AW-1:0] mem_addr_q;
  logic [7:0]    mem_do_q;
  logic          mem_ce_q;
  logic          mem_oe_q;
  logic          mem_we_q;

  logic          pi_pulse;
  logic          pi_req;
  logic          pi_miss_clr;
  logic          pi_free;
  logic          grant_pi;
  logic          grant_host;
  logic          unused_pi_addr;

  // Bits above the memory width only participate in the hit decode.
  assign unused_pi_addr = ^pi_addr_i;

  always_comb begin
    pi_pulse    = pi_we_sync_i | pi_oe_sync_i;
    pi_req      = pi_pend_q & pi_hit_q;
    // Round robin on contention: PI wins when the host had the last grant.
    grant_pi    = (state_q == ST_IDLE) & pi_req & (~host_req_i | last_host_q);
    grant_host  = (state_q == ST_IDLE) & host_req_i & (~pi_req | ~last_host_q);
    // A miss never reaches the FSM; its slot frees one clk after capture.
    pi_miss_clr = pi_pend_q & ~pi_hit_q;
    // The slot is free if empty or being vacated in this very clk.
    pi_free     = ~pi_pend_q | grant_pi | pi_miss_clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cur_pi_q     <= 1'b0;
      cur_rw_q     <= 1'b0;
      last_host_q  <= 1'b1;
      pi_pend_q    <= 1'b0;
      pi_hit_q     <= 1'b0;
      pi_rw_q      <= 1'b0;
      pi_addr_q    <= '0;
      pi_dat_q     <= '0;
      pi_ovf_q     <= 1'b0;
      pi_dati_q    <= 8'hFF;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_do_q     <= '0;
      mem_ce_q     <= 1'b0;
      mem_oe_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      // PiBus request slot
      if (pi_pulse) begin
        if (pi_free) begin
          pi_pend_q <= 1'b1;
          pi_hit_q  <= (pi_addr_i[31:24] == PI_BASE);
          pi_rw_q   <= pi_we_sync_i;
          pi_addr_q <= pi_addr_i[AW-1:0];
          pi_dat_q  <= pi_dato_i;
        end else begin
          pi_ovf_q  <= 1'b1;
        end
      end else if (grant_pi || pi_miss_clr) begin
        pi_pend_q <= 1'b0;
      end

      if (pi_miss_clr && !pi_rw_q) begin
        pi_dati_q <= 8'hFF;
      end

      host_ack_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (grant_pi || grant_host) begin
            cur_pi_q    <= grant_pi;
            cur_rw_q    <= grant_pi ? pi_rw_q   : host_we_i;
            mem_addr_q  <= grant_pi ? pi_addr_q : host_addr_i;
            mem_do_q    <= grant_pi ? pi_dat_q  : host_wdata_i;
            mem_ce_q    <= 1'b1;
            last_host_q <= grant_host;
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          mem_oe_q <= ~cur_rw_q;
          mem_we_q <= cur_rw_q;
          cnt_q    <= 4'(MEM_CYC - 1);
          state_q  <= ST_STROBE;
        end
        ST_STROBE: begin
          if (cnt_q == 4'd0) begin
            mem_oe_q <= 1'b0;
            mem_we_q <= 1'b0;
            // Last strobe clk: SRAM data is settled, capture it.
            if (!cur_rw_q) begin
              if (cur_pi_q) pi_dati_q    <= mem_di_i;
              else          host_rdata_q <= mem_di_i;
            end
            if (!cur_pi_q) host_ack_q <= 1'b1;
            state_q <= ST_RECOV;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RECOV: begin
          // Address/data stay driven through this clk for write hold time.
          mem_ce_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pi_dati_o    = pi_dati_q;
  assign pi_ovf_o     = pi_ovf_q;
  assign host_ack_o   = host_ack_q;
  assign host_rdata_o = host_rdata_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_do_o     = mem_do_q;
  assign mem_ce_o     = mem_ce_q;
  assign mem_oe_o     = mem_oe_q;
  assign mem_we_o     = mem_we_q;

endmodule
`default_nettype wire
